// File: rtl/afifo_arb_pkg.sv
// Shared constants for the AFIFO write-port arbiter: word width, state encoding
// and the parameter legality check used at elaboration.
package afifo_arb_pkg;

    localparam int unsigned AFIFO_W = 12;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StBurst = 1'b1;

    // ID must fill exactly the bits the payload leaves free, and address every requester.
    function automatic bit cfg_ok(int unsigned n_req, int unsigned id_w,
                                  int unsigned data_w, int unsigned burst);
        return (id_w + data_w == AFIFO_W) && (n_req == (32'd1 << id_w)) &&
               (n_req >= 2) && (n_req <= 8) && (burst >= 1) && (burst <= 255);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of valid scanning ptr, ptr+1, ...
// with wrap-around; index arithmetic wraps naturally because N_REQ == 2**ID_W.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic             any,
    output logic [ID_W-1:0]  idx
);

    logic [ID_W-1:0] cand;

    // Scan from the farthest offset down so the nearest valid index wins last.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + ID_W'(k);
            if (valid[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Round-robin arbiter sharing one AFIFO write port between N_REQ producers,
// granting bounded bursts and tagging each word with the source ID.
module afifo_wr_arbiter
    import afifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ID_W   = 2,
    parameter int unsigned DATA_W = 10,
    parameter int unsigned BURST  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    w,
    output logic [AFIFO_W-1:0]      wd,
    input  logic                    wok,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy
);

    if (!cfg_ok(N_REQ, ID_W, DATA_W, BURST)) begin : g_cfg_err
        $error("afifo_wr_arbiter: illegal N_REQ/ID_W/DATA_W/BURST combination");
    end

    logic [0:0]        state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              pick_any;
    logic [ID_W-1:0]   pick_idx;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic              xfer;
    logic              last_word;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == ID_W'(i)) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_valid = req_valid[grant_q];
    assign busy      = (state_q == StBurst);
    assign w         = busy & sel_valid;
    assign wd        = w ? {grant_q, sel_data} : '0;
    assign grant_id  = grant_q;
    assign xfer      = w & wok;
    assign last_word = (cnt_q == 8'(BURST - 1));

    always_comb begin
        req_ready = '0;
        if (busy) begin
            req_ready[grant_q] = wok;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        if (state_q == StIdle) begin
            if (pick_any) begin
                grant_d = pick_idx;
                cnt_d   = '0;
                state_d = StBurst;
            end
        end else begin
            // A transfer outranks release: the handshake forbids both on one edge.
            if (xfer) begin
                cnt_d = cnt_q + 8'd1;
                if (last_word) begin
                    state_d  = StIdle;
                    rr_ptr_d = grant_q + ID_W'(1);
                end
            end else if (!sel_valid) begin
                state_d  = StIdle;
                rr_ptr_d = grant_q + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Self-checking bench for afifo_wr_arbiter: bench-side producers, a wd scoreboard
// queue, and per-scenario tasks checking timing, stalls, release and reset.
module tb_afifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [39:0] req_data;
    logic [3:0]  req_ready;
    logic        w;
    logic [11:0] wd;
    logic        wok;
    logic [1:0]  grant_id;
    logic        busy;

    afifo_wr_arbiter #(
        .N_REQ  (4),
        .ID_W   (2),
        .DATA_W (10),
        .BURST  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .w         (w),
        .wd        (wd),
        .wok       (wok),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    logic [11:0] exp_q[$];
    bit          mode_id;
    bit          rand_wok;
    int          limit[4];
    int          taken[4];
    logic [9:0]  pd[4];
    bit          cnt_en[4];
    logic [9:0]  exp_next[4];
    int          cyc;
    int          stall_lo;
    int          stall_hi;
    int          last_xfer;

    logic        s_w;
    logic [11:0] s_wd;
    logic [3:0]  s_rdy;
    logic        s_busy;
    logic [1:0]  s_gid;

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]          = (taken[i] < limit[i]);
            req_data[i*10 +: 10]  = pd[i];
        end
        if (rand_wok) wok = ($urandom_range(0, 3) != 0);
        else          wok = !((cyc >= stall_lo) && (cyc < stall_hi));
    endtask

    task automatic clear_producers();
        for (int i = 0; i < 4; i++) begin
            limit[i]    = 0;
            taken[i]    = 0;
            pd[i]       = '0;
            cnt_en[i]   = 1'b0;
            exp_next[i] = '0;
        end
        exp_q.delete();
        mode_id   = 1'b0;
        rand_wok  = 1'b0;
        stall_lo  = -1;
        stall_hi  = -1;
        cyc       = 0;
        last_xfer = -1;
    endtask

    // One clock: sample at the negedge, score any transfer, then advance producers.
    task automatic tick();
        logic [3:0]  acc;
        logic [11:0] e;
        int          id;
        @(negedge clk);
        s_w    = w;
        s_wd   = wd;
        s_rdy  = req_ready;
        s_busy = busy;
        s_gid  = grant_id;
        acc    = req_valid & req_ready;
        if (w && wok) begin
            last_xfer = cyc;
            checks++;
            if (!mode_id) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wd_extra cyc=%0d: got write %h, expected no write", cyc, wd);
                end else begin
                    e = exp_q.pop_front();
                    if (wd !== e) begin
                        errors++;
                        $display("FAIL wd_seq cyc=%0d: got %h expected %h", cyc, wd, e);
                    end
                end
            end else begin
                id = int'(wd[11:10]);
                if (wd[9:0] !== exp_next[id]) begin
                    errors++;
                    $display("FAIL id_continuity id=%0d: got %h expected %h",
                             id, wd[9:0], exp_next[id]);
                end
                exp_next[id] = exp_next[id] + 10'd1;
            end
        end
        if (!wok) begin
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL ready_when_full cyc=%0d: got %b expected 0000", cyc, req_ready);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                taken[i]++;
                if (cnt_en[i]) pd[i] = pd[i] + 10'd1;
            end
        end
        drive();
    endtask

    task automatic test_reset();
        clear_producers();
        drive();
        rst = 1'b1;
        @(negedge clk);
        checks += 5;
        if (w !== 1'b0)         begin errors++; $display("FAIL reset_w: got %b expected 0", w); end
        if (wd !== 12'h000)     begin errors++; $display("FAIL reset_wd: got %h expected 000", wd); end
        if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (grant_id !== 2'd0)  begin errors++; $display("FAIL reset_gid: got %0d expected 0", grant_id); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit exp_w;
        test_reset();
        limit[0] = 1000; pd[0] = 10'h001; cnt_en[0] = 1'b1;
        for (int k = 1; k <= 16; k++) exp_q.push_back(12'(k));
        drive();
        for (int c = 0; c < 18; c++) begin
            tick();
            exp_w = ((c % 9) != 0);
            checks++;
            if (s_w !== exp_w) begin
                errors++;
                $display("FAIL single_w cyc=%0d: got %b expected %b", c, s_w, exp_w);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_words: %0d words missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        int guard;
        test_reset();
        for (int i = 0; i < 4; i++) begin
            limit[i] = 1000; pd[i] = 10'(i);
        end
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 8; k++) exp_q.push_back({2'(r % 4), 10'(r % 4)});
        end
        drive();
        guard = 0;
        while (exp_q.size() != 0 && guard < 80) begin
            tick();
            guard++;
        end
        checks += 2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_timeout: %0d words missing, expected 0", exp_q.size());
        end
        if (last_xfer != 44) begin
            errors++;
            $display("FAIL rr_timing: last word at cycle %0d expected 44", last_xfer);
        end
    endtask

    task automatic test_stall();
        test_reset();
        limit[1] = 1000; pd[1] = 10'h010; cnt_en[1] = 1'b1;
        stall_lo = 4; stall_hi = 9;
        for (int k = 0; k < 8; k++) exp_q.push_back({2'd1, 10'(16 + k)});
        drive();
        for (int c = 0; c < 15; c++) begin
            tick();
            checks++;
            if (s_busy !== ((c >= 1) && (c <= 13))) begin
                errors++;
                $display("FAIL stall_busy cyc=%0d: got %b", c, s_busy);
            end
            if (c >= 4 && c <= 8) begin
                checks += 3;
                if (s_w !== 1'b1)     begin errors++; $display("FAIL stall_w cyc=%0d: got %b expected 1", c, s_w); end
                if (s_wd !== 12'h413) begin errors++; $display("FAIL stall_wd cyc=%0d: got %h expected 413", c, s_wd); end
                if (s_rdy !== 4'b0)   begin errors++; $display("FAIL stall_ready cyc=%0d: got %b expected 0000", c, s_rdy); end
            end
        end
        checks++;
        if (exp_q.size() != 0 || taken[1] != 8) begin
            errors++;
            $display("FAIL stall_count: took %0d words expected 8", taken[1]);
        end
    endtask

    task automatic test_release();
        test_reset();
        limit[2] = 2; pd[2] = 10'h020; cnt_en[2] = 1'b1;
        limit[3] = 8; pd[3] = 10'h030; cnt_en[3] = 1'b1;
        exp_q.push_back(12'h820);
        exp_q.push_back(12'h821);
        for (int k = 0; k < 8; k++) exp_q.push_back({2'd3, 10'(48 + k)});
        drive();
        for (int c = 0; c < 14; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if (s_gid !== 2'd2) begin errors++; $display("FAIL release_first_gid: got %0d expected 2", s_gid); end
            end
            if (c == 3) begin
                checks++;
                if (s_w !== 1'b0) begin errors++; $display("FAIL release_w: got %b expected 0", s_w); end
            end
            if (c == 4) begin
                checks++;
                if (s_busy !== 1'b0) begin errors++; $display("FAIL release_idle: busy %b expected 0", s_busy); end
            end
            if (c == 5) begin
                checks += 2;
                if (s_gid !== 2'd3) begin errors++; $display("FAIL release_next_gid: got %0d expected 3", s_gid); end
                if (s_w !== 1'b1)   begin errors++; $display("FAIL release_next_w: got %b expected 1", s_w); end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL release_words: %0d words missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        test_reset();
        limit[3] = 1000; pd[3] = 10'h3F0; cnt_en[3] = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back({2'd3, 10'(10'h3F0 + k)});
        drive();
        for (int c = 0; c < 4; c++) tick();
        #2;
        rst = 1'b1;
        #1;
        checks += 4;
        if (w !== 1'b0)         begin errors++; $display("FAIL midrst_w: got %b expected 0", w); end
        if (req_ready !== 4'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0000", req_ready); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        if (wd !== 12'h000)     begin errors++; $display("FAIL midrst_wd: got %h expected 000", wd); end
        limit[1] = 1000; pd[1] = 10'h111; cnt_en[1] = 1'b1;
        exp_q.push_back(12'h511);
        drive();
        #2;
        rst = 1'b0;
        tick();
        checks += 3;
        if (s_gid !== 2'd1) begin errors++; $display("FAIL midrst_gid: got %0d expected 1", s_gid); end
        if (s_w !== 1'b1)   begin errors++; $display("FAIL midrst_regrant_w: got %b expected 1", s_w); end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_words: %0d words missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_random_wok();
        int guard;
        bit done;
        test_reset();
        mode_id  = 1'b1;
        rand_wok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            limit[i] = 150; pd[i] = 10'(i * 100); cnt_en[i] = 1'b1; exp_next[i] = 10'(i * 100);
        end
        drive();
        guard = 0;
        done  = 1'b0;
        while (!done && guard < 3000) begin
            tick();
            guard++;
            done = (taken[0] == 150) && (taken[1] == 150) && (taken[2] == 150) && (taken[3] == 150);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (exp_next[i] !== 10'(i * 100 + 150)) begin
                errors++;
                $display("FAIL random_total id=%0d: next %0d expected %0d", i, exp_next[i], i * 100 + 150);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        wok       = 1'b1;
        clear_producers();
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_release();
        test_mid_reset();
        test_random_wok();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/afifo_wr_arbiter.md
Name: afifo_wr_arbiter

Overview:
- Round-robin arbiter sharing the single AFIFO write port (w, wd, wok) between N_REQ producers in the write-clock domain.
- Grants one producer at a time for a bounded burst.
- Tags each word with the source ID in the upper wd bits, so the read side can demultiplex and check per-source sequence continuity.
- Sits between producer logic and the AFIFO write side, clocked by the AFIFO write clock.

Parameters:
- N_REQ, 4: number of requesters; must be a power of two, 2..8.
- ID_W, 2: source-ID width; must equal log2(N_REQ).
- DATA_W, 10: payload width per requester; ID_W+DATA_W = 12 = AFIFO word width.
- BURST, 8: maximum words accepted per grant; legal range 1..255.

Ports:
- clk, in, 1: write clock; same clock as the AFIFO wclk.
- rst, in, 1: asynchronous, active-high reset.
- req_valid, in, N_REQ: per-requester word-available flag.
- req_data, in, N_REQ*DATA_W: requester i's payload is at bits [i*DATA_W +: DATA_W].
- req_ready, out, N_REQ: per-requester accept strobe; a word transfers when req_valid[i] && req_ready[i].
- w, out, 1: AFIFO write enable.
- wd, out, 12: AFIFO write data, {grant_id, payload}.
- wok, in, 1: AFIFO not-full; a write commits on a clk edge where w && wok.
- grant_id, out, ID_W: currently or last granted requester.
- busy, out, 1: high while in BURST.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, cnt=0, grant_id=0. All outputs read 0: w, wd, req_ready and busy are combinational from state, so they are 0 in IDLE.
- Registered state: state {IDLE, BURST}, grant_id, rr_ptr (ID_W bits), cnt (8 bits).
- IDLE:
  - w=0, wd=0, req_ready=0.
  - If any req_valid: pick the first valid index scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - Register that index as grant_id, set cnt=0, go to BURST.
  - Arbitration latency is exactly 1 cycle, from req_valid seen in IDLE to w asserted.
- BURST:
  - w = req_valid[grant_id].
  - wd = req_valid[grant_id] ? {grant_id, req_data[grant_id]} : 0.
  - req_ready[grant_id] = wok; all other req_ready bits = 0.
  - busy = 1.
- Transfer (w && wok at a clk edge): cnt <= cnt+1. If cnt == BURST-1: state <= IDLE, rr_ptr <= grant_id+1 (wraps modulo N_REQ).
- Requester release: if req_valid[grant_id] is 0 at a clk edge in BURST, then state <= IDLE, rr_ptr <= grant_id+1. Words already transferred stand; no timeout.
- Stall: wok=0 with w=1 means no transfer. w stays 1, wd is held, cnt is unchanged, and the grant is kept indefinitely.
- Requester rule: while req_valid && !req_ready, req_data must be stable and req_valid must not drop. Verification asserts this; the arbiter does not check it.
- Every grant is followed by exactly one IDLE cycle before the next grant, including a re-grant to the same requester. Sustained throughput is BURST/(BURST+1).
- Fairness: with all requesters continuously valid, grant order is rr_ptr, rr_ptr+1, ... cyclically. No requester waits more than (N_REQ-1) bursts plus stalls.
- Reset mid-burst: outputs drop to 0 immediately (combinational from async-cleared state). A partially transferred burst is simply truncated. Arbitration after reset release starts from index 0.
- Simultaneous final-word transfer and req_valid drop: impossible by the handshake rule; the transfer takes precedence.

Decomposition:
- Package afifo_arb_pkg:
  - state encoding (IDLE=0, BURST=1);
  - AFIFO_W=12;
  - a static check that ID_W+DATA_W == AFIFO_W and N_REQ == 2**ID_W.
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: valid[N_REQ], ptr[ID_W].
  - Outputs: any, idx[ID_W].
  - Instantiated once in IDLE-state next-grant logic.

Test Plan:
1. Only req 0 valid continuously, payload counting 0x001 upward, wok=1, BURST=8 → w low 1 cycle, then wd=0x001..0x008 on 8 consecutive cycles, w low 1 cycle, then wd=0x009..
2. All 4 valid, wok=1, payload = requester index → wd sequence 8×0x000, gap, 8×0x401, gap, 8×0x802, gap, 8×0xC03, gap, 8×0x000; per-requester order preserved.
3. Req 1 granted; wok=0 for 5 cycles after its 3rd word → w=1, wd held, req_ready[1]=0 for those 5 cycles; exactly 5 more words follow, 8 total; busy high throughout.
4. Req 2 drops valid after 2 words while req 3 is valid → IDLE next cycle, then grant_id=3 (rr_ptr=3); req 2's 2 words present with wd[11:10]=2.
5. rst pulsed asynchronously mid-burst on req 3 (between edges) → w, req_ready, busy read 0 within the same cycle; after release with reqs 1 and 3 valid, first grant_id=1.
6. Integration with the AFIFO: 4 counting producers, reader clock ratio 60/84 ns, 100k words → reader sees each ID's payload incrementing by 1 with no gaps; no write issued while wok=0.
